time_set_ctrl: RTL

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven editor for an hour/minute/second setting held
// in packed BCD. tick_prog enters edit mode; up/down change the selected
// field; left/right move the cursor. A second tick_prog emits a one-cycle
// commit pulse so the RTC writer can load the edited values.
module time_set_ctrl #(
    parameter int HOUR_MAX = 23,
    parameter int HOUR_MIN = 0
) (
    input  logic       clkr,
    input  logic       resetr,
    input  logic       tick_prog,
    input  logic       tick_up,
    input  logic       tick_down,
    input  logic       tick_left,
    input  logic       tick_right,
    output logic       prog_mode,
    output logic [1:0] field_sel,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       commit
);

    // Hour bounds converted once into packed BCD so the wrap test is a plain compare
    localparam logic [7:0] HMAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam logic [7:0] HMIN_BCD = {4'(HOUR_MIN / 10), 4'(HOUR_MIN % 10)};

    localparam logic [1:0] SEL_HR  = 2'b00;
    localparam logic [1:0] SEL_MIN = 2'b01;
    localparam logic [1:0] SEL_SEC = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        EDIT_HR,
        EDIT_MIN,
        EDIT_SEC,
        COMMIT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hour_nxt;
    logic [7:0] min_nxt;
    logic [7:0] sec_nxt;

    // Minute/second increment: 59 wraps to 00, digits stay in 0..9 / 0..5
    function automatic logic [7:0] ms_up(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = v[7:4];
        u = v[3:0];
        if (u == 4'd9) begin
            u = 4'd0;
            t = (t == 4'd5) ? 4'd0 : t + 4'd1;
        end else begin
            u = u + 4'd1;
        end
        return {t, u};
    endfunction

    // Minute/second decrement: 00 wraps to 59
    function automatic logic [7:0] ms_down(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = v[7:4];
        u = v[3:0];
        if (u == 4'd0) begin
            u = 4'd9;
            t = (t == 4'd0) ? 4'd5 : t - 4'd1;
        end else begin
            u = u - 4'd1;
        end
        return {t, u};
    endfunction

    // Hour increment: wraps at the configured maximum, otherwise a BCD step
    function automatic logic [7:0] hr_up(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = v[7:4];
        u = v[3:0];
        if (v == HMAX_BCD) begin
            return HMIN_BCD;
        end
        if (u == 4'd9) begin
            u = 4'd0;
            t = t + 4'd1;
        end else begin
            u = u + 4'd1;
        end
        return {t, u};
    endfunction

    // Hour decrement: wraps at the configured minimum, otherwise a BCD step
    function automatic logic [7:0] hr_down(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = v[7:4];
        u = v[3:0];
        if (v == HMIN_BCD) begin
            return HMAX_BCD;
        end
        if (u == 4'd0) begin
            u = 4'd9;
            t = t - 4'd1;
        end else begin
            u = u - 4'd1;
        end
        return {t, u};
    endfunction

    // Next state and next field values; only the highest-priority tick acts
    always_comb begin
        state_nxt = state;
        hour_nxt  = hour_bcd;
        min_nxt   = min_bcd;
        sec_nxt   = sec_bcd;
        case (state)
            IDLE: begin
                if (tick_prog) begin
                    state_nxt = EDIT_HR;
                end
            end
            EDIT_HR, EDIT_MIN, EDIT_SEC: begin
                if (tick_prog) begin
                    state_nxt = COMMIT;
                end else if (tick_up) begin
                    case (state)
                        EDIT_HR:  hour_nxt = hr_up(hour_bcd);
                        EDIT_MIN: min_nxt  = ms_up(min_bcd);
                        default:  sec_nxt  = ms_up(sec_bcd);
                    endcase
                end else if (tick_down) begin
                    case (state)
                        EDIT_HR:  hour_nxt = hr_down(hour_bcd);
                        EDIT_MIN: min_nxt  = ms_down(min_bcd);
                        default:  sec_nxt  = ms_down(sec_bcd);
                    endcase
                end else if (tick_right) begin
                    case (state)
                        EDIT_HR:  state_nxt = EDIT_MIN;
                        EDIT_MIN: state_nxt = EDIT_SEC;
                        default:  state_nxt = EDIT_HR;
                    endcase
                end else if (tick_left) begin
                    case (state)
                        EDIT_HR:  state_nxt = EDIT_SEC;
                        EDIT_MIN: state_nxt = EDIT_HR;
                        default:  state_nxt = EDIT_MIN;
                    endcase
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, field values and decoded outputs all registered from the next state
    always_ff @(posedge clkr or posedge resetr) begin
        if (resetr) begin
            state     <= IDLE;
            hour_bcd  <= HMIN_BCD;
            min_bcd   <= 8'h00;
            sec_bcd   <= 8'h00;
            prog_mode <= 1'b0;
            field_sel <= SEL_HR;
            commit    <= 1'b0;
        end else begin
            state     <= state_nxt;
            hour_bcd  <= hour_nxt;
            min_bcd   <= min_nxt;
            sec_bcd   <= sec_nxt;
            prog_mode <= (state_nxt == EDIT_HR) || (state_nxt == EDIT_MIN) ||
                         (state_nxt == EDIT_SEC);
            commit    <= (state_nxt == COMMIT);
            case (state_nxt)
                EDIT_MIN: field_sel <= SEL_MIN;
                EDIT_SEC: field_sel <= SEL_SEC;
                default:  field_sel <= SEL_HR;
            endcase
        end
    end

endmodule
